// File: rtl/key_display.sv
// Captures key presses from the keypad scanner into a two-digit history and
// drives a multiplexed common-anode dual seven-segment display with blanking gaps.
module key_display #(
    parameter int MUX_DIV = 20000,
    parameter int GUARD   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_pressed,
    input  logic [3:0] value,
    output logic [3:0] recent,
    output logic [3:0] older,
    output logic       new_key,
    output logic [6:0] seg,
    output logic [1:0] anode
);
    localparam int LMAX = (MUX_DIV > GUARD) ? MUX_DIV : GUARD;
    localparam int CW   = $clog2(LMAX);

    typedef enum logic [1:0] {SHOW_R, GAP_RO, SHOW_O, GAP_OR} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt, len_m1;
    logic            key_prev;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Rising edge of key_pressed; the scanner has already debounced it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_prev <= 1'b0;
            recent   <= 4'h0;
            older    <= 4'h0;
            new_key  <= 1'b0;
        end else begin
            key_prev <= key_pressed;
            new_key  <= 1'b0;
            if (key_pressed && !key_prev) begin
                older   <= recent;
                recent  <= value;
                new_key <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= GAP_OR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        len_m1    = CW'(GUARD - 1);
        if (state == SHOW_R || state == SHOW_O)
            len_m1 = CW'(MUX_DIV - 1);
        if (cnt == len_m1) begin
            cnt_nxt = '0;
            case (state)
                SHOW_R:  state_nxt = GAP_RO;
                GAP_RO:  state_nxt = SHOW_O;
                SHOW_O:  state_nxt = GAP_OR;
                default: state_nxt = SHOW_R;
            endcase
        end
    end

    // Outputs follow the current state one edge later; gaps keep both digits dark.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode <= 2'b11;
            seg   <= 7'b1111111;
        end else begin
            case (state)
                SHOW_R: begin
                    anode <= 2'b10;
                    seg   <= decode(recent);
                end
                SHOW_O: begin
                    anode <= 2'b01;
                    seg   <= decode(older);
                end
                default: begin
                    anode <= 2'b11;
                    seg   <= 7'b1111111;
                end
            endcase
        end
    end
endmodule
